// File: rtl/wr_ptr_ctrl_gray.sv
// Write-side pointer controller for a dual-clock FIFO: binary/Gray write pointer, read-pointer synchroniser, full/almost-full/count/overflow.
// Latency: memWrEn/wrAddr combinational; flags and count registered on the accepting edge; read-side frees visible SYNC_STAGES+1 edges later.
// Backpressure: writes are refused while fifoFull is high; a refused write sets the sticky overflow flag and moves no pointer.
module wr_ptr_ctrl_gray #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wrClk,
  input  logic              wrRst,
  input  logic              wrEn,
  input  logic [ADDR_W:0]   rdPtrGray,
  input  logic [ADDR_W:0]   almostFullThresh,
  input  logic              overflowClr,
  output logic              memWrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [ADDR_W:0]   wrPtrGray,
  output logic              fifoFull,
  output logic              almostFull,
  output logic [ADDR_W:0]   wrCount,
  output logic              overflow
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wrBin;
  logic [PW-1:0] wrBinNext;
  logic [PW-1:0] wrGrayNext;
  logic [PW-1:0] rdGraySync;
  logic [PW-1:0] rdBinSync;
  logic [PW-1:0] fullGray;
  logic [PW-1:0] fillNext;
  logic [PW-1:0] syncQ [SYNC_STAGES];

  // Accept a write only when not full and not in reset; address is the low bits of the binary pointer
  always_comb begin
    memWrEn    = wrEn & ~fifoFull & ~wrRst;
    wrAddr     = wrBin[ADDR_W-1:0];
    wrBinNext  = wrBin + PW'(memWrEn);
    wrGrayNext = wrBinNext ^ (wrBinNext >> 1);
  end

  // Read pointer crosses into the write domain through a plain flop chain (Gray code keeps it single-bit per step)
  always_ff @(posedge wrClk or posedge wrRst) begin
    if (wrRst) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncQ[i] <= '0;
    end else begin
      syncQ[0] <= rdPtrGray;
      for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
    end
  end

  // Gray-to-binary of the synchronised read pointer; full pattern is read pointer with top two bits inverted
  always_comb begin
    rdGraySync = syncQ[SYNC_STAGES-1];
    for (int i = 0; i < PW; i++) rdBinSync[i] = ^(rdGraySync >> i);
    fullGray = {~rdGraySync[ADDR_W:ADDR_W-1], rdGraySync[ADDR_W-2:0]};
    fillNext = wrBinNext - rdBinSync;
  end

  // Pointers, flags and count all update from next-state values so full asserts on the filling edge
  always_ff @(posedge wrClk or posedge wrRst) begin
    if (wrRst) begin
      wrBin      <= '0;
      wrPtrGray  <= '0;
      fifoFull   <= 1'b0;
      almostFull <= 1'b0;
      wrCount    <= '0;
    end else begin
      wrBin      <= wrBinNext;
      wrPtrGray  <= wrGrayNext;
      fifoFull   <= (wrGrayNext == fullGray);
      almostFull <= (almostFullThresh != '0) && (fillNext >= almostFullThresh);
      wrCount    <= fillNext;
    end
  end

  // Sticky overflow: a write attempt while full sets it, and set beats a simultaneous clear
  always_ff @(posedge wrClk or posedge wrRst) begin
    if (wrRst) begin
      overflow <= 1'b0;
    end else if (wrEn && fifoFull) begin
      overflow <= 1'b1;
    end else if (overflowClr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wr_ptr_ctrl_gray.sv
// Bench for wr_ptr_ctrl_gray with ADDR_W=3, SYNC_STAGES=2.
// Table of per-cycle vectors for fill/overflow/drain, plus hand sequences for wrap and async reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled before the next edge.
module tb_wr_ptr_ctrl_gray;

  localparam int AW = 3;
  localparam int PW = AW + 1;

  logic          wrClk = 1'b0;
  logic          wrRst;
  logic          wrEn;
  logic [PW-1:0] rdPtrGray;
  logic [PW-1:0] almostFullThresh;
  logic          overflowClr;
  logic          memWrEn;
  logic [AW-1:0] wrAddr;
  logic [PW-1:0] wrPtrGray;
  logic          fifoFull;
  logic          almostFull;
  logic [PW-1:0] wrCount;
  logic          overflow;

  int checks = 0;
  int passes = 0;

  wr_ptr_ctrl_gray #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .wrClk(wrClk), .wrRst(wrRst), .wrEn(wrEn), .rdPtrGray(rdPtrGray),
    .almostFullThresh(almostFullThresh), .overflowClr(overflowClr),
    .memWrEn(memWrEn), .wrAddr(wrAddr), .wrPtrGray(wrPtrGray),
    .fifoFull(fifoFull), .almostFull(almostFull), .wrCount(wrCount), .overflow(overflow)
  );

  always #5 wrClk = ~wrClk;

  typedef struct {
    logic          wrEn;
    logic [PW-1:0] rd;
    logic          clr;
    logic          expMem;
    logic [AW-1:0] expAddr;
    logic [PW-1:0] expGray;
    logic          expFull;
    logic          expAf;
    logic [PW-1:0] expCnt;
    logic          expOvf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic we, input logic [PW-1:0] rd, input logic clr,
                              input logic mem, input logic [AW-1:0] addr, input logic [PW-1:0] g,
                              input logic full, input logic af, input logic [PW-1:0] cnt, input logic ovf);
    vec_t v;
    v.wrEn = we; v.rd = rd; v.clr = clr; v.expMem = mem; v.expAddr = addr;
    v.expGray = g; v.expFull = full; v.expAf = af; v.expCnt = cnt; v.expOvf = ovf;
    return v;
  endfunction

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chkAllZero(input string tag);
    chk({tag, "_memWrEn"}, memWrEn, 0);
    chk({tag, "_wrAddr"}, wrAddr, 0);
    chk({tag, "_wrPtrGray"}, wrPtrGray, 0);
    chk({tag, "_fifoFull"}, fifoFull, 0);
    chk({tag, "_almostFull"}, almostFull, 0);
    chk({tag, "_wrCount"}, wrCount, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    logic [PW-1:0] grayTab [8];
    logic [PW-1:0] prevGray;
    logic [PW-1:0] expG;

    grayTab[0] = 4'd1; grayTab[1] = 4'd3; grayTab[2] = 4'd2; grayTab[3] = 4'd6;
    grayTab[4] = 4'd7; grayTab[5] = 4'd5; grayTab[6] = 4'd4; grayTab[7] = 4'hC;

    // fill 8 entries with read pointer at 0, threshold 6
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1, AW'(i), grayTab[i], i == 7, i >= 5, PW'(i + 1), 1'b0));
    // write while full: refused, overflow sets, pointer holds
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b1));
    // clear together with a refused write: set wins
    vecs.push_back(mk(1'b1, 4'd0, 1'b1, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b1));
    // clear alone
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0));
    // read pointer advances to gray(3): visible on the third edge
    vecs.push_back(mk(1'b0, 4'b0010, 1'b0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b0, 1'b0, 3'd0, 4'hC, 1'b0, 1'b0, 4'd5, 1'b0));
    // next write accepted at address 0
    vecs.push_back(mk(1'b1, 4'b0010, 1'b0, 1'b1, 3'd0, 4'hD, 1'b0, 1'b1, 4'd6, 1'b0));

    // reset: everything zero even with wrEn high, also across an edge
    wrRst = 1'b1; wrEn = 1'b1; rdPtrGray = '0; almostFullThresh = 4'd6; overflowClr = 1'b0;
    #1;
    chkAllZero("rst_async");
    @(posedge wrClk); #1;
    chkAllZero("rst_edge");
    wrRst = 1'b0;

    foreach (vecs[k]) begin
      wrEn = vecs[k].wrEn; rdPtrGray = vecs[k].rd; overflowClr = vecs[k].clr;
      #1;
      chk($sformatf("v%0d_memWrEn", k), memWrEn, vecs[k].expMem);
      chk($sformatf("v%0d_wrAddr", k), wrAddr, vecs[k].expAddr);
      @(posedge wrClk); #1;
      chk($sformatf("v%0d_wrPtrGray", k), wrPtrGray, vecs[k].expGray);
      chk($sformatf("v%0d_fifoFull", k), fifoFull, vecs[k].expFull);
      chk($sformatf("v%0d_almostFull", k), almostFull, vecs[k].expAf);
      chk($sformatf("v%0d_wrCount", k), wrCount, vecs[k].expCnt);
      chk($sformatf("v%0d_overflow", k), overflow, vecs[k].expOvf);
    end

    // wrap: 20 writes, read pointer trailing by 2
    wrRst = 1'b1; wrEn = 1'b0; rdPtrGray = '0; overflowClr = 1'b0;
    #1;
    wrRst = 1'b0;
    prevGray = '0;
    for (int n = 0; n < 20; n++) begin
      wrEn = 1'b1;
      rdPtrGray = gray(PW'((n >= 2) ? n - 2 : 0));
      #1;
      chk($sformatf("wrap%0d_wrAddr", n), wrAddr, n % 8);
      @(posedge wrClk); #1;
      expG = gray(PW'(n + 1));
      chk($sformatf("wrap%0d_wrPtrGray", n), wrPtrGray, expG);
      chk($sformatf("wrap%0d_oneBit", n), $countones(wrPtrGray ^ prevGray), 1);
      chk($sformatf("wrap%0d_fifoFull", n), fifoFull, 0);
      prevGray = wrPtrGray;
    end

    // async reset between edges, mid-burst
    wrEn = 1'b1;
    @(posedge wrClk); #1;
    chk("pre_rst_nonzero", wrPtrGray != 0, 1);
    #2;
    wrRst = 1'b1;
    #1;
    chkAllZero("midrst");
    rdPtrGray = '0;
    @(posedge wrClk); #1;
    chk("midrst_hold_gray", wrPtrGray, 0);
    wrRst = 1'b0;
    #1;
    chk("post_rst_memWrEn", memWrEn, 1);
    chk("post_rst_wrAddr", wrAddr, 0);
    @(posedge wrClk); #1;
    chk("post_rst_wrCount", wrCount, 1);
    chk("post_rst_wrPtrGray", wrPtrGray, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
